// File: rtl/program_loader_if.sv
// program_loader_if: byte-wide valid/ready image stream plus the PM write port.
interface program_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              pm_wr_en;
   logic [ADDR_W-1:0] pm_wr_addr;
   logic [7:0]        pm_wr_data;
   modport master (
      output in_data, in_valid,
      input  in_ready, pm_wr_en, pm_wr_addr, pm_wr_data
   );
   modport slave (
      input  in_data, in_valid,
      output in_ready, pm_wr_en, pm_wr_addr, pm_wr_data
   );
endinterface

// File: rtl/program_loader.sv
// program_loader: streams a LEN/data/checksum image into PM from address 0, holding the core in reset until verified.
// Optional idle watchdog (err_code 3) is built when LOADER_TIMEOUT_EN is defined.
module program_loader #(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   program_loader_if.slave bus,
   output logic            cpu_sync_reset,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [1:0]      err_code
);
   localparam int MAX_LEN = ADDR_W >= 8 ? 255 : (1 << ADDR_W) - 1;
   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
   state_t            state_q, state_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        sum_q, sum_d;
   logic [1:0]        code_q, code_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              active, xfer, timeout;
   assign active = state_q == LEN || state_q == DATA || state_q == CSUM;
   assign xfer   = active && bus.in_valid;
`ifdef LOADER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   // Counter is zero outside the loading states, so entry to LEN starts it cleared.
   always_comb begin
      wd_d    = '0;
      timeout = 1'b0;
      if (active && !xfer) begin
         timeout = wd_q == WD_W'(TIMEOUT_CYCLES - 1);
         wd_d    = wd_q + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) wd_q <= '0;
      else          wd_q <= wd_d;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      code_d    = code_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_q)
         LEN:
            if (xfer) begin
               if (bus.in_data == 8'd0 || int'(bus.in_data) > MAX_LEN) begin
                  state_d = ERR;
                  code_d  = 2'd1;
               end else begin
                  len_d   = bus.in_data;
                  state_d = DATA;
               end
            end
         DATA:
            if (xfer) begin
               wr_en_d   = 1'b1;
               wr_addr_d = ADDR_W'(cnt_q);
               wr_data_d = bus.in_data;
               sum_d     = sum_q + bus.in_data;
               cnt_d     = cnt_q + 8'd1;
               state_d   = cnt_q + 8'd1 == len_q ? CSUM : DATA;
            end
         CSUM:
            if (xfer) begin
               state_d = 8'(sum_q + bus.in_data) == 8'd0 ? DONE : ERR;
               code_d  = 8'(sum_q + bus.in_data) == 8'd0 ? code_q : 2'd2;
            end
         default:
            if (start) begin
               state_d = LEN;
               code_d  = 2'd0;
               cnt_d   = '0;
               sum_d   = '0;
            end
      endcase
      if (timeout) begin
         state_d = ERR;
         code_d  = 2'd3;
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         sum_q     <= '0;
         code_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         code_q    <= code_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   assign bus.in_ready   = active;
   assign bus.pm_wr_en   = wr_en_q;
   assign bus.pm_wr_addr = wr_addr_q;
   assign bus.pm_wr_data = wr_data_q;
   assign busy           = active;
   assign done           = state_q == DONE;
   assign err            = state_q == ERR;
   assign cpu_sync_reset = state_q != DONE;
   assign err_code       = code_q;
endmodule
